// File: rtl/ex_stage_pkg.sv
// ex_stage shared definitions: ALU command codes, ID/EX and EX/MEM field
// layouts, and the multiplier FSM state encoding.
// Optional multiplier support is controlled by the EX_MUL_EN macro.
package ex_stage_pkg;

    localparam int DATA_W   = 16;
    localparam int ID_EX_W  = 58;
    localparam int EX_MEM_W = 38;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SL   = 4'd6;
    localparam logic [3:0] ALU_SR   = 4'd7;
    localparam logic [3:0] ALU_SAR  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;

    // ID/EX register layout, MSB first: [57:54] cmd ... [0] wb result mux
    typedef struct packed {
        logic [3:0]        alu_cmd;
        logic [DATA_W-1:0] alu_src1;
        logic [DATA_W-1:0] alu_src2;
        logic              mem_write_en;
        logic [DATA_W-1:0] mem_write_data;
        logic              write_back_en;
        logic [2:0]        write_back_dest;
        logic              write_back_result_mux;
    } id_ex_t;

    // EX/MEM register layout, MSB first: [37:22] result ... [0] wb result mux
    typedef struct packed {
        logic [DATA_W-1:0] ex_alu_result;
        logic              mem_write_en;
        logic [DATA_W-1:0] mem_write_data;
        logic              write_back_en;
        logic [2:0]        write_back_dest;
        logic              write_back_result_mux;
    } ex_mem_t;

`ifdef EX_MUL_EN
    // One iteration per data bit; must equal DATA_W.
    localparam int EX_MUL_CYCLES = 16;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_RUN  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_t;
`endif

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage pipeline interface: ID/EX input, EX/MEM output and the hazard
// unit signals (destination forwarding and stall request).
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [ID_EX_W-1:0]  pipeline_reg_in;
    logic [EX_MEM_W-1:0] pipeline_reg_out;
    logic [2:0]          ex_op_dest;
    logic                ex_stall_req;

    // master: the pipeline around EX (ID stage, MEM stage, hazard unit)
    modport master (
        output pipeline_reg_in,
        input  pipeline_reg_out,
        input  ex_op_dest,
        input  ex_stall_req
    );

    // slave: the execute stage itself
    modport slave (
        input  pipeline_reg_in,
        output pipeline_reg_out,
        output ex_op_dest,
        output ex_stall_req
    );
endinterface

// File: rtl/ex_stage_mul16_iter.sv
// mul16_iter: iterative shift-add multiplier with fixed latency, one bit of
// the multiplier per cycle. Only present when EX_MUL_EN is defined.
//
//   state   | meaning
//   EX_IDLE | waiting for i_start; operands latched on start
//   EX_RUN  | one shift-add iteration per cycle, MUL_CYCLES iterations
//   EX_DONE | o_product valid for one cycle, then back to EX_IDLE
`ifdef EX_MUL_EN
module mul16_iter
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = EX_MUL_CYCLES
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_multiplicand,
    input  logic [DATA_W-1:0] i_multiplier,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    localparam int              CNT_W     = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

    ex_state_t         r_state;
    ex_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              w_last;

    assign w_last    = (r_count == LAST_ITER);
    assign o_product = r_acc;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and status decode
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            EX_IDLE: begin
                if (i_start) begin
                    w_state_nxt = EX_RUN;
                end
            end
            EX_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = EX_DONE;
                end
            end
            EX_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = EX_IDLE;
            end
            default: begin
                w_state_nxt = EX_IDLE;
            end
        endcase
    end

    // shift-add datapath; runs all iterations even for trivial operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == EX_IDLE && i_start) begin
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == EX_RUN) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit 5-stage pipeline. Single-cycle ALU
// into the EX/MEM register; with EX_MUL_EN defined, MUL runs on the
// iterative multiplier and stalls upstream until the product is committed.
// Without EX_MUL_EN, MUL is a reserved command and the stall is tied low.
module ex_stage
    import ex_stage_pkg::*;
`ifdef EX_MUL_EN
#(
    parameter int MUL_CYCLES = EX_MUL_CYCLES
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    id_ex_t            w_id;
    ex_mem_t           w_alu_out;
    logic [DATA_W-1:0] w_alu_result;
    logic [EX_MEM_W-1:0] r_out;

    assign w_id                 = id_ex_t'(bus.pipeline_reg_in);
    assign bus.pipeline_reg_out = r_out;
    assign bus.ex_op_dest       = w_id.write_back_dest;

    // single-cycle ALU; MUL yields 0 here, its product comes from mul16_iter
    always_comb begin
        w_alu_result = '0;
        case (w_id.alu_cmd)
            ALU_NONE: w_alu_result = '0;
            ALU_ADD:  w_alu_result = w_id.alu_src1 + w_id.alu_src2;
            ALU_SUB:  w_alu_result = w_id.alu_src1 - w_id.alu_src2;
            ALU_AND:  w_alu_result = w_id.alu_src1 & w_id.alu_src2;
            ALU_OR:   w_alu_result = w_id.alu_src1 | w_id.alu_src2;
            ALU_XOR:  w_alu_result = w_id.alu_src1 ^ w_id.alu_src2;
            ALU_SL:   w_alu_result = w_id.alu_src1 << w_id.alu_src2[3:0];
            ALU_SR:   w_alu_result = w_id.alu_src1 >> w_id.alu_src2[3:0];
            ALU_SAR:  w_alu_result = $signed(w_id.alu_src1) >>> w_id.alu_src2[3:0];
            ALU_MUL:  w_alu_result = '0;
            default:  w_alu_result = '0;
        endcase
    end

    // memory and write-back fields pass straight through with the result
    always_comb begin
        w_alu_out                       = '0;
        w_alu_out.ex_alu_result         = w_alu_result;
        w_alu_out.mem_write_en          = w_id.mem_write_en;
        w_alu_out.mem_write_data        = w_id.mem_write_data;
        w_alu_out.write_back_en         = w_id.write_back_en;
        w_alu_out.write_back_dest       = w_id.write_back_dest;
        w_alu_out.write_back_result_mux = w_id.write_back_result_mux;
    end

`ifdef EX_MUL_EN
    logic              w_is_mul;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;
    logic              w_stall;
    ex_mem_t           w_mul_out;

    assign w_is_mul = (w_id.alu_cmd == ALU_MUL);
    // stall from the moment MUL shows up in IDLE through the last iteration;
    // released in DONE so ID/EX advances on the commit edge
    assign w_stall          = w_mul_busy || (w_is_mul && !w_mul_done);
    assign bus.ex_stall_req = w_stall;

    mul16_iter #(
        .MUL_CYCLES     (MUL_CYCLES)
    ) u_mul (
        .clk            (clk),
        .rst            (rst),
        .i_start        (w_is_mul),
        .i_multiplicand (w_id.alu_src1),
        .i_multiplier   (w_id.alu_src2),
        .o_busy         (w_mul_busy),
        .o_done         (w_mul_done),
        .o_product      (w_product)
    );

    // commit record for the finished product; control fields are the held MUL's
    always_comb begin
        w_mul_out               = w_alu_out;
        w_mul_out.ex_alu_result = w_product;
    end

    // EX/MEM register: product on DONE, bubble while stalling, else ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_mul_done) begin
            r_out <= w_mul_out;
        end else if (w_stall) begin
            r_out <= '0;
        end else begin
            r_out <= w_alu_out;
        end
    end
`else
    assign bus.ex_stall_req = 1'b0;

    // EX/MEM register: every command completes in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_alu_out;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table of single-cycle ALU vectors plus
// hand-written multi-cycle sequences (MUL, back-to-back MUL, mid-MUL reset).
// Follows the build: MUL sequences with EX_MUL_EN, reserved-MUL checks without.
module tb_ex_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic stall_seen;

    ex_stage_if bus();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.ex_stall_req === 1'b1) stall_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic        mwe;
        logic [15:0] mwd;
        logic        wbe;
        logic [2:0]  dest;
        logic        mux;
        logic [15:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                         input logic mwe, input logic [15:0] mwd, input logic wbe,
                         input logic [2:0] dest, input logic mux);
        bus.pipeline_reg_in = {cmd, a, b, mwe, mwd, wbe, dest, mux};
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive a MUL at a negedge; expects 17 stall cycles with bubbles, then the
    // product on the 18th edge. Returns at the negedge after the commit.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [2:0] dest,
                           input logic [15:0] exp, input string name);
        int          n;
        logic        bubble_bad;
        logic [21:0] tail;
        n          = 0;
        bubble_bad = 1'b0;
        drive(4'd9, a, b, 1'b0, 16'h0ABC, 1'b1, dest, 1'b1);
        tail = bus.pipeline_reg_in[21:0];
        #1;
        check({name, " stall at start"}, 64'(bus.ex_stall_req), 64'd1);
        while (bus.ex_stall_req === 1'b1 && n < 40) begin
            if (n > 0 && bus.pipeline_reg_out !== 38'd0) bubble_bad = 1'b1;
            check({name, " dest while stalled"}, 64'(bus.ex_op_dest), 64'(dest));
            step();
            n++;
        end
        check({name, " stall cycles"}, 64'(n), 64'd17);
        check({name, " bubbles during stall"}, 64'(bubble_bad), 64'd0);
        check({name, " no early commit"}, 64'(bus.pipeline_reg_out), 64'd0);
        step();
        check({name, " product"}, 64'(bus.pipeline_reg_out), 64'({exp, tail}));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        stall_seen = 1'b0;

        vecs[0]  = '{4'd1, 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 16'h8000, "add overflow"};
        vecs[1]  = '{4'd2, 16'h0000, 16'h0001, 1'b0, 16'h1111, 1'b1, 3'd1, 1'b0, 16'hFFFF, "sub wrap"};
        vecs[2]  = '{4'd8, 16'h8000, 16'h0004, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'hF800, "sar neg"};
        vecs[3]  = '{4'd7, 16'h8000, 16'h0004, 1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0, 16'h0800, "sr"};
        vecs[4]  = '{4'd6, 16'h0001, 16'h000F, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b0, 16'h8000, "sl by 15"};
        vecs[5]  = '{4'd3, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0, 16'h3030, "and"};
        vecs[6]  = '{4'd4, 16'hF0F0, 16'h0F01, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 16'hFFF1, "or"};
        vecs[7]  = '{4'd5, 16'hAAAA, 16'hFFFF, 1'b1, 16'h5A5A, 1'b0, 3'd6, 1'b1, 16'h5555, "xor"};
        vecs[8]  = '{4'd0, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 16'h0000, "none"};
        vecs[9]  = '{4'd12, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 16'h0000, "reserved 12"};
        vecs[10] = '{4'd6, 16'h00FF, 16'h0014, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 16'h0FF0, "sl uses src2[3:0]"};
        vecs[11] = '{4'd8, 16'h4000, 16'h000E, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0, 16'h0001, "sar positive"};
        vecs[12] = '{4'd15, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h0000, "reserved 15"};

        rst = 1'b1;
        bus.pipeline_reg_in = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset out", 64'(bus.pipeline_reg_out), 64'd0);
        check("reset stall", 64'(bus.ex_stall_req), 64'd0);
        rst = 1'b0;

        // first ADD: result plus write-back fields
        drive(4'd1, 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0);
        step();
        check("add result", 64'(bus.pipeline_reg_out[37:22]), 64'h8000);
        check("add wb fields", 64'(bus.pipeline_reg_out[4:1]), 64'b1011);
        check("add stall", 64'(bus.ex_stall_req), 64'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].mwe, vecs[i].mwd,
                  vecs[i].wbe, vecs[i].dest, vecs[i].mux);
            #1;
            check({vecs[i].name, " stall"}, 64'(bus.ex_stall_req), 64'd0);
            check({vecs[i].name, " op dest"}, 64'(bus.ex_op_dest), 64'(vecs[i].dest));
            step();
            check(vecs[i].name, 64'(bus.pipeline_reg_out),
                  64'({vecs[i].exp, vecs[i].mwe, vecs[i].mwd, vecs[i].wbe, vecs[i].dest, vecs[i].mux}));
        end

`ifdef EX_MUL_EN
        run_mul(16'h0123, 16'h0045, 3'd5, 16'h4E6F, "mul 0123x0045");
        check("mul dest field", 64'(bus.pipeline_reg_out[3:1]), 64'd5);
        drive(4'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
        step();

        run_mul(16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, "mul ffffxffff");
        drive(4'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
        step();

        run_mul(16'h0000, 16'h1234, 3'd6, 16'h0000, "mul 0x1234");
        drive(4'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
        step();

        // back-to-back: second MUL is driven right after the first commit, so
        // the only non-stall cycle between windows is the DONE cycle
        run_mul(16'd3, 16'd4, 3'd1, 16'h000C, "b2b mul 3x4");
        run_mul(16'd5, 16'd6, 3'd2, 16'h001E, "b2b mul 5x6");
        drive(4'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
        step();
        check("after b2b bubble", 64'(bus.pipeline_reg_out), 64'd0);

        // reset while RUN with count = 7 (8 edges after MUL appears)
        drive(4'd9, 16'h0123, 16'h0045, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0);
        for (int k = 0; k < 8; k++) step();
        check("mid-mul stall", 64'(bus.ex_stall_req), 64'd1);
        check("mid-mul bubble", 64'(bus.pipeline_reg_out), 64'd0);
        rst = 1'b1;
        step();
        check("mid-mul reset out", 64'(bus.pipeline_reg_out), 64'd0);
        drive(4'd1, 16'h0002, 16'h0003, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0);
        #1;
        check("post-reset stall idle", 64'(bus.ex_stall_req), 64'd0);
        rst = 1'b0;
        step();
        check("post-reset add", 64'(bus.pipeline_reg_out),
              64'({16'h0005, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0}));
        step();
        check("no late mul commit", 64'(bus.pipeline_reg_out[37:22]), 64'h0005);
`else
        // MUL is reserved: zero result, one-cycle latency, no stall
        drive(4'd9, 16'd3, 16'd4, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0);
        #1;
        check("reserved mul stall", 64'(bus.ex_stall_req), 64'd0);
        step();
        check("reserved mul out", 64'(bus.pipeline_reg_out),
              64'({16'h0000, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0}));
        drive(4'd1, 16'd3, 16'd4, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0);
        step();
        check("add after mul", 64'(bus.pipeline_reg_out[37:22]), 64'h0007);
        check("stall never asserted", 64'(stall_seen), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit 5-stage pipeline; sits between ID_stage and MEM_stage.
- Computes the ALU result from decoded operands and registers it, with memory and write-back control fields, into the 38-bit EX/MEM pipeline register in MEM_stage format.
- Adds an iterative 16-cycle shift-add multiplier. It stalls upstream through a request to the hazard detection unit.

Parameters:
- MUL_CYCLES, 16, number of multiplier iterations. Must equal the data width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- pipeline_reg_in  input  58  from ID_stage:
  - [57:54] alu_cmd
  - [53:38] alu_src1
  - [37:22] alu_src2
  - [21] mem_write_en
  - [20:5] mem_write_data
  - [4] write_back_en
  - [3:1] write_back_dest
  - [0] write_back_result_mux
- pipeline_reg_out  output  38  to MEM_stage:
  - [37:22] ex_alu_result
  - [21] mem_write_en
  - [20:5] mem_write_data
  - [4:0] write-back fields
- ex_op_dest  output  3  pipeline_reg_in[3:1], combinational, to hazard unit
- ex_stall_req  output  1  to hazard unit; holds PC, IF/ID and ID/EX while high

Behaviour:
- Reset: pipeline_reg_out = 0, FSM = IDLE, iteration counter = 0, multiplier regs = 0.
  - ex_stall_req = 0 after reset unless alu_cmd = MUL is present.
  - Reset mid-multiply aborts immediately; no result is written.
- alu_cmd encoding:
  - 0 NONE: result 0
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SL: src1 << src2[3:0]
  - 7 SR: logical right shift
  - 8 SAR: arithmetic right shift
  - 9 MUL
  - 10-15 reserved: result 0
- Arithmetic: all 16-bit, wrap-around, no flags. MUL yields the low 16 bits of the product.
- Non-MUL, FSM IDLE: one-cycle latency.
  - Each edge, pipeline_reg_out <= {result, pipeline_reg_in[21:0]}.
  - ex_stall_req = 0.
- FSM states IDLE, RUN, DONE:
  - IDLE, alu_cmd = MUL:
    - ex_stall_req = 1 combinationally.
    - At the edge: latch multiplicand = src1, multiplier = src2, acc = 0, count = 0; go to RUN.
    - pipeline_reg_out <= 0 (bubble).
  - RUN, each cycle:
    - If multiplier[0], acc += multiplicand.
    - Multiplicand <<= 1, multiplier >>= 1, count++.
    - ex_stall_req = 1; pipeline_reg_out <= 0.
    - After the MUL_CYCLES-th iteration (count = 15 at edge), go to DONE.
  - DONE:
    - ex_stall_req = 0.
    - At the edge: pipeline_reg_out <= {acc, pipeline_reg_in[21:0]}; go to IDLE.
    - ID/EX advances on the same edge, so the next MUL is not re-triggered by a stale input.
- MUL timing: stall high for exactly 17 consecutive cycles; result visible in pipeline_reg_out on the 18th edge after the MUL appears.
- Upstream must hold pipeline_reg_in stable while ex_stall_req = 1. The block samples control fields only in IDLE and DONE.
- Bubbles have write_back_en = 0 and mem_write_en = 0, so MEM and WB take no architectural action.
- Back-to-back MULs: DONE -> IDLE, then the new MUL starts the next cycle. No gap other than the DONE cycle.
- Operand 0 or 0xFFFF: the loop still runs the full 16 iterations (fixed latency).
- ex_op_dest is valid in all states.

Optional Feature:
- EX_MUL_EN defined:
  - Iterative multiplier and FSM are present, as described above.
- EX_MUL_EN undefined:
  - alu_cmd 9 is treated as reserved: result 0, one-cycle latency.
  - ex_stall_req is tied to 0.
  - No FSM or multiplier registers are synthesised.

Decomposition:
- mips_16_defs.v holds:
  - ALU_NONE..ALU_MUL command constants
  - EX/MEM and ID/EX field bit positions
  - FSM state encodings EX_IDLE/EX_RUN/EX_DONE
- One sub-module: mul16_iter (start, operands, busy, done, product), instantiated only under EX_MUL_EN.
- The ALU combinational mux stays inline.

Test Plan:
- rst high 2 cycles, then ADD src1=0x7FFF, src2=0x0001, wb_en=1, dest=3 -> next edge:
  - pipeline_reg_out[37:22] = 0x8000
  - [4:1] = 4'b1011
  - ex_stall_req = 0
- SUB 0x0000 - 0x0001 -> 0xFFFF.
- SAR 0x8000 by 4 -> 0xF800.
- SR 0x8000 by 4 -> 0x0800.
- SL 0x0001 by 15 -> 0x8000.
- MUL 0x0123 x 0x0045, mem_write_en=0, wb_en=1, dest=5 held while stall:
  - stall high 17 cycles, pipeline_reg_out = 0 throughout.
  - Then result 0x4E6F with dest 5.
- MUL 0xFFFF x 0xFFFF -> 0x0001. MUL 0x0000 x 0x1234 -> 0x0000, still 17 stall cycles.
- Back-to-back MUL(3,4), MUL(5,6):
  - results 0x000C and 0x001E on edges 18 and 36.
  - exactly one non-stall cycle between the stall windows.
- Assert rst at RUN count=7 -> next edge:
  - pipeline_reg_out = 0, FSM IDLE, no 0-result commit.
  - With a non-MUL input after reset, ex_stall_req = 0.
- Build without EX_MUL_EN: MUL 3x4 -> result 0 after 1 cycle, ex_stall_req never asserted.
